// File: rtl/wb_master_arbiter_if.sv
// wb_master_arbiter_if: Wishbone classic bus bundle between one master and one slave
interface wb_master_arbiter_if #(
   parameter int ADR_WIDTH = 24,
   parameter int DAT_WIDTH = 32
);
   logic                 cyc;
   logic                 stb;
   logic                 we;
   logic [ADR_WIDTH-1:0] adr;
   logic [DAT_WIDTH-1:0] dat_m;
   logic [DAT_WIDTH-1:0] dat_s;
   logic                 ack;
   logic                 err;
   modport master (output cyc, stb, we, adr, dat_m, input dat_s, ack, err);
   modport slave  (input cyc, stb, we, adr, dat_m, output dat_s, ack, err);
endinterface

// File: rtl/wb_master_arbiter.sv
// wb_master_arbiter: round-robin, cycle-locked sharing of one Wishbone master port with ack timeout
module wb_master_arbiter #(
   parameter int                   ADR_WIDTH      = 24,
   parameter int                   DAT_WIDTH      = 32,
   parameter int                   TIMEOUT_CYCLES = 1024,
   parameter logic [DAT_WIDTH-1:0] ERR_DATA       = 32'hDEADC0DE
) (
   input  logic                       clk,
   input  logic                       rst_n,
   wb_master_arbiter_if.slave         m0,
   wb_master_arbiter_if.slave         m1,
   wb_master_arbiter_if.master        s,
   output logic [1:0]                 grant_o
);
   localparam int            CW  = $clog2(TIMEOUT_CYCLES) + 1;
   localparam logic [CW-1:0] LIM = CW'(TIMEOUT_CYCLES - 1);
   typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;
   state_t        state_q, state_d;
   logic          last_q, last_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          to_q, to_d;
   logic          err_q, err_d;
   logic          own0, own1, sel_cyc, sel_stb, acked, expire;
   assign own0    = state_q == OWN0;
   assign own1    = state_q == OWN1;
   assign sel_cyc = own0 ? m0.cyc : own1 & m1.cyc;
   assign sel_stb = own0 ? m0.stb : own1 & m1.stb;
   assign grant_o = {own1, own0};
   // bus steering from the registered grant; a timed-out transfer keeps stb off the bus
   always_comb begin
      s.cyc    = own0 | own1;
      s.stb    = sel_cyc & sel_stb & ~to_q;
      s.we     = own0 ? m0.we : own1 & m1.we;
      s.adr    = own0 ? m0.adr : own1 ? m1.adr : {ADR_WIDTH{1'b0}};
      s.dat_m  = own0 ? m0.dat_m : own1 ? m1.dat_m : {DAT_WIDTH{1'b0}};
      acked    = s.stb & s.ack;
      expire   = s.stb & ~s.ack & (cnt_q == LIM);
      m0.ack   = own0 & acked;
      m1.ack   = own1 & acked;
      m0.err   = own0 & err_q;
      m1.err   = own1 & err_q;
      m0.dat_s = m0.ack ? s.dat_s : m0.err ? ERR_DATA : {DAT_WIDTH{1'b0}};
      m1.dat_s = m1.ack ? s.dat_s : m1.err ? ERR_DATA : {DAT_WIDTH{1'b0}};
   end
   // ack timeout: saturating wait counter, one-cycle err pulse, abort flag held until the master drops stb
   always_comb begin
      cnt_d = (!s.stb || s.ack) ? '0 : (cnt_q == LIM) ? cnt_q : cnt_q + CW'(1);
      to_d  = to_q ? (sel_cyc & sel_stb) : expire;
      err_d = expire;
   end
   // arbitration: grant from idle only, alternate on a tie, hold until the owner drops cyc
   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      case (state_q)
         IDLE: begin
            if (m0.cyc && (!m1.cyc || last_q)) begin
               state_d = OWN0;
               last_d  = 1'b0;
            end else if (m1.cyc) begin
               state_d = OWN1;
               last_d  = 1'b1;
            end
         end
         OWN0:    state_d = m0.cyc ? OWN0 : IDLE;
         OWN1:    state_d = m1.cyc ? OWN1 : IDLE;
         default: state_d = IDLE;
      endcase
   end
   // state registers with synchronous active-low reset; M1 as last owner lets M0 win the first tie
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         last_q  <= 1'b1;
         cnt_q   <= '0;
         to_q    <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         cnt_q   <= cnt_d;
         to_q    <= to_d;
         err_q   <= err_d;
      end
   end
endmodule

// File: tb/tb_wb_master_arbiter.sv
// tb_wb_master_arbiter: directed checks of grant, lock, round-robin, timeout and reset behaviour
module tb_wb_master_arbiter;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [1:0] grant;
   int         errors = 0;
   int         checks = 0;
   wb_master_arbiter_if #(.ADR_WIDTH(24), .DAT_WIDTH(32)) m0_if ();
   wb_master_arbiter_if #(.ADR_WIDTH(24), .DAT_WIDTH(32)) m1_if ();
   wb_master_arbiter_if #(.ADR_WIDTH(24), .DAT_WIDTH(32)) s_if ();
   wb_master_arbiter #(.ADR_WIDTH(24), .DAT_WIDTH(32), .TIMEOUT_CYCLES(16), .ERR_DATA(32'hDEADC0DE)) dut (
      .clk(clk), .rst_n(rst_n), .m0(m0_if.slave), .m1(m1_if.slave), .s(s_if.master), .grant_o(grant)
   );
   always #5 clk = ~clk;
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   initial begin
      m0_if.cyc = 0; m0_if.stb = 0; m0_if.we = 0; m0_if.adr = 0; m0_if.dat_m = 0;
      m1_if.cyc = 0; m1_if.stb = 0; m1_if.we = 0; m1_if.adr = 0; m1_if.dat_m = 0;
      s_if.ack = 0; s_if.dat_s = 0; s_if.err = 0;
      tick(); tick();
      #1;
      chk("rst_grant", 64'(grant), 0);
      chk("rst_scyc", 64'(s_if.cyc), 0);
      chk("rst_sstb", 64'(s_if.stb), 0);
      chk("rst_m0ack", 64'(m0_if.ack), 0);
      chk("rst_m1err", 64'(m1_if.err), 0);
      chk("rst_m0dat", 64'(m0_if.dat_s), 0);
      // single M0 read
      tick(); rst_n = 1;
      tick(); m0_if.cyc = 1; m0_if.stb = 1; m0_if.adr = 24'h000100; #1;
      chk("rd_scyc_n", 64'(s_if.cyc), 0);
      tick(); #1;
      chk("rd_scyc_n1", 64'(s_if.cyc), 1);
      chk("rd_sstb", 64'(s_if.stb), 1);
      chk("rd_sadr", 64'(s_if.adr), 64'h100);
      chk("rd_grant", 64'(grant), 1);
      tick(); #1;
      chk("rd_noack", 64'(m0_if.ack), 0);
      tick(); s_if.ack = 1; s_if.dat_s = 32'h12345678; #1;
      chk("rd_m0ack", 64'(m0_if.ack), 1);
      chk("rd_m0dat", 64'(m0_if.dat_s), 64'h12345678);
      chk("rd_m1ack", 64'(m1_if.ack), 0);
      chk("rd_m1dat", 64'(m1_if.dat_s), 0);
      tick(); s_if.ack = 0; m0_if.cyc = 0; m0_if.stb = 0; #1;
      chk("rd_ackdrop", 64'(m0_if.ack), 0);
      chk("rd_datdrop", 64'(m0_if.dat_s), 0);
      tick(); #1;
      chk("rd_idle_grant", 64'(grant), 0);
      chk("rd_idle_scyc", 64'(s_if.cyc), 0);
      // simultaneous requests after reset: M0 first, then M1
      rst_n = 0; tick(); rst_n = 1;
      tick(); m0_if.cyc = 1; m0_if.stb = 1; m0_if.adr = 24'h000AAA;
      m1_if.cyc = 1; m1_if.stb = 1; m1_if.adr = 24'h000BBB;
      tick(); s_if.ack = 1; s_if.dat_s = 32'h0000_1111; #1;
      chk("rr_grant0", 64'(grant), 1);
      chk("rr_m0ack", 64'(m0_if.ack), 1);
      chk("rr_m1ack0", 64'(m1_if.ack), 0);
      tick(); s_if.ack = 0; m0_if.cyc = 0; m0_if.stb = 0;
      tick(); m0_if.cyc = 1; m0_if.stb = 1; #1;
      chk("rr_idle", 64'(grant), 0);
      chk("rr_idle_scyc", 64'(s_if.cyc), 0);
      tick(); s_if.ack = 1; s_if.dat_s = 32'h0000_2222; #1;
      chk("rr_grant1", 64'(grant), 2);
      chk("rr_sadr1", 64'(s_if.adr), 64'hBBB);
      chk("rr_m1ack", 64'(m1_if.ack), 1);
      chk("rr_m1dat", 64'(m1_if.dat_s), 64'h2222);
      chk("rr_m0ack0", 64'(m0_if.ack), 0);
      tick(); s_if.ack = 0; m0_if.cyc = 0; m0_if.stb = 0; m1_if.cyc = 0; m1_if.stb = 0;
      tick(); tick(); #1;
      chk("rr_end_grant", 64'(grant), 0);
      // M0 locks the bus for four writes while M1 waits
      m0_if.cyc = 1; m0_if.stb = 1; m0_if.we = 1; m1_if.cyc = 1; m1_if.stb = 1;
      tick();
      for (int i = 0; i < 4; i++) begin
         m0_if.adr = 24'h000200 + 24'(i); m0_if.dat_m = 32'hA000_0000 + 32'(i); s_if.ack = 1; #1;
         chk("lk_grant", 64'(grant), 1);
         chk("lk_swe", 64'(s_if.we), 1);
         chk("lk_sadr", 64'(s_if.adr), 64'h200 + 64'(i));
         chk("lk_sdat", 64'(s_if.dat_m), 64'hA000_0000 + 64'(i));
         chk("lk_m0ack", 64'(m0_if.ack), 1);
         tick();
      end
      s_if.ack = 0; m0_if.cyc = 0; m0_if.stb = 0; m0_if.we = 0; #1;
      chk("lk_release_grant", 64'(grant), 1);
      tick(); #1;
      chk("lk_gap_grant", 64'(grant), 0);
      chk("lk_gap_scyc", 64'(s_if.cyc), 0);
      tick(); #1;
      chk("lk_m1_grant", 64'(grant), 2);
      m1_if.cyc = 0; m1_if.stb = 0;
      tick(); tick();
      // M1 read with no ack: timeout after 16 cycles, late ack ignored, then recovery
      m1_if.cyc = 1; m1_if.stb = 1; m1_if.we = 0; m1_if.adr = 24'hFFF000;
      tick(); #1;
      chk("to_sstb0", 64'(s_if.stb), 1);
      chk("to_grant", 64'(grant), 2);
      for (int k = 1; k < 16; k++) begin
         tick(); #1;
         chk("to_noerr", 64'(m1_if.err), 0);
      end
      chk("to_sstb15", 64'(s_if.stb), 1);
      tick(); #1;
      chk("to_err", 64'(m1_if.err), 1);
      chk("to_errdat", 64'(m1_if.dat_s), 64'hDEADC0DE);
      chk("to_sstb_off", 64'(s_if.stb), 0);
      chk("to_ack0", 64'(m1_if.ack), 0);
      tick(); #1;
      chk("to_err_pulse", 64'(m1_if.err), 0);
      chk("to_stb_held_off", 64'(s_if.stb), 0);
      chk("to_dat0", 64'(m1_if.dat_s), 0);
      tick(); tick();
      tick(); s_if.ack = 1; s_if.dat_s = 32'h5555_AAAA; #1;
      chk("to_late_ack", 64'(m1_if.ack), 0);
      chk("to_late_err", 64'(m1_if.err), 0);
      chk("to_late_dat", 64'(m1_if.dat_s), 0);
      tick(); s_if.ack = 0; m1_if.stb = 0;
      tick(); m1_if.stb = 1; s_if.ack = 1; s_if.dat_s = 32'h0BAD_F00D; #1;
      chk("to_recover_stb", 64'(s_if.stb), 1);
      chk("to_recover_ack", 64'(m1_if.ack), 1);
      chk("to_recover_dat", 64'(m1_if.dat_s), 64'h0BAD_F00D);
      tick(); s_if.ack = 0; m1_if.cyc = 0; m1_if.stb = 0;
      tick(); tick();
      // ack on the exact timeout cycle wins
      m0_if.cyc = 1; m0_if.stb = 1; m0_if.adr = 24'h000300;
      tick();
      for (int k = 1; k < 16; k++) tick();
      s_if.ack = 1; s_if.dat_s = 32'hCAFE_F00D; #1;
      chk("edge_ack", 64'(m0_if.ack), 1);
      chk("edge_dat", 64'(m0_if.dat_s), 64'hCAFE_F00D);
      chk("edge_err", 64'(m0_if.err), 0);
      tick(); s_if.ack = 0; m0_if.stb = 0; #1;
      chk("edge_err_next", 64'(m0_if.err), 0);
      tick(); #1;
      chk("edge_err_next2", 64'(m0_if.err), 0);
      m0_if.cyc = 0;
      tick(); tick();
      // reset while M1 owns the bus with stb pending
      m1_if.cyc = 1; m1_if.stb = 1;
      tick(); tick(); #1;
      chk("rs_grant1", 64'(grant), 2);
      rst_n = 0; #1;
      chk("rs_noack", 64'(m1_if.ack), 0);
      chk("rs_noerr", 64'(m1_if.err), 0);
      tick(); #1;
      chk("rs_scyc", 64'(s_if.cyc), 0);
      chk("rs_grant", 64'(grant), 0);
      chk("rs_err_after", 64'(m1_if.err), 0);
      rst_n = 1; m1_if.cyc = 0; m1_if.stb = 0;
      tick(); m0_if.cyc = 1; m0_if.stb = 1; m1_if.cyc = 1; m1_if.stb = 1;
      tick(); #1;
      chk("rs_tie_m0", 64'(grant), 1);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
